// File: rtl/alu_pc_unit.sv
// Execute-stage slice of a single-cycle MIPS core: PC register, ALU control decoder and 32-bit ALU.
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_pc_unit #(
    parameter int          WORD       = 32,
    parameter logic [WORD-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] next_addr,
    output logic [WORD-1:0] curr_addr,
    output logic [WORD-1:0] pc_plus4,
    input  logic [5:0]      funct,
    input  logic [1:0]      alu_op,
    output logic [3:0]      alu_control,
    input  logic [WORD-1:0] alu_a,
    input  logic [WORD-1:0] alu_b,
    output logic [WORD-1:0] alu_result,
`ifdef ALU_OVERFLOW_EN
    output logic            overflow,
`endif
    output logic            zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic [WORD-1:0] pc_q;
    logic [WORD-1:0] pc_d;
    logic [WORD-1:0] sum;
    logic [WORD-1:0] diff;
    logic            slt_bit;

    assign pc_d = next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign curr_addr = pc_q;
    assign pc_plus4  = pc_q + WORD'(4);

    always_comb begin
        alu_control = OP_BAD;
        unique case (alu_op)
            2'b00: alu_control = OP_ADD;
            2'b01: alu_control = OP_SUB;
            2'b11: alu_control = OP_AND;
            default: begin
                case (funct)
                    6'b100000: alu_control = OP_ADD;
                    6'b100010: alu_control = OP_SUB;
                    6'b100100: alu_control = OP_AND;
                    6'b100101: alu_control = OP_OR;
                    6'b100111: alu_control = OP_NOR;
                    6'b101010: alu_control = OP_SLT;
                    default:   alu_control = OP_BAD;
                endcase
            end
        endcase
    end

    assign sum     = alu_a + alu_b;
    assign diff    = alu_a - alu_b;
    assign slt_bit = $signed(alu_a) < $signed(alu_b);

    always_comb begin
        alu_result = '0;
        case (alu_control)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            OP_ADD:  alu_result = sum;
            OP_SUB:  alu_result = diff;
            OP_SLT:  alu_result = {{(WORD-1){1'b0}}, slt_bit};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

`ifdef ALU_OVERFLOW_EN
    // Sign-bit rules: add overflows on like-signed operands, sub on unlike-signed ones.
    always_comb begin
        overflow = 1'b0;
        if (alu_control == OP_ADD) begin
            overflow = (alu_a[WORD-1] == alu_b[WORD-1]) && (sum[WORD-1] != alu_a[WORD-1]);
        end else if (alu_control == OP_SUB) begin
            overflow = (alu_a[WORD-1] != alu_b[WORD-1]) && (diff[WORD-1] != alu_a[WORD-1]);
        end
    end
`endif

endmodule

// File: tb/tb_alu_pc_unit.sv
// Directed self-checking bench for alu_pc_unit (PC register, ALU decoder, ALU).
// Overflow checks are compiled in when ALU_OVERFLOW_EN is defined.
module tb_alu_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_addr;
    logic [31:0] curr_addr;
    logic [31:0] pc_plus4;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic [3:0]  alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_addr   (next_addr),
        .curr_addr   (curr_addr),
        .pc_plus4    (pc_plus4),
        .funct       (funct),
        .alu_op      (alu_op),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
`ifdef ALU_OVERFLOW_EN
        .overflow    (overflow),
`endif
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
        alu_op = op;
        funct  = fn;
        alu_a  = a;
        alu_b  = b;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        next_addr = 32'h0000_0040;
        alu_op    = 2'b00;
        funct     = 6'b0;
        alu_a     = 32'h0;
        alu_b     = 32'h0;
        #1;
        check("rst_curr", curr_addr, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);

        // edge at t=5 lands during reset and must be ignored
        @(negedge clk);
        check("rst_edge_ign", curr_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_load", curr_addr, 32'h40);
        check("first_pc4", pc_plus4, 32'h44);

        next_addr = 32'h0000_0100;
        @(posedge clk); #1;
        check("run_100", curr_addr, 32'h100);

        next_addr = 32'h0000_0200;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", curr_addr, 32'h0);
        @(posedge clk); #1;
        check("edge_in_rst", curr_addr, 32'h0);
        check("edge_in_rst4", pc_plus4, 32'h4);

        @(negedge clk);
        rst_n     = 1'b1;
        next_addr = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        check("pc_top", curr_addr, 32'hFFFF_FFFC);
        check("pc4_wrap", pc_plus4, 32'h0);

        alu(2'b10, 6'b100000, 32'h0000_000F, 32'h0000_00F0);
        check("r_add_ctl", {28'h0, alu_control}, 32'h2);
        check("r_add", alu_result, 32'h0000_00FF);
        alu(2'b10, 6'b100010, 32'h0000_000F, 32'h0000_00F0);
        check("r_sub_ctl", {28'h0, alu_control}, 32'h6);
        check("r_sub", alu_result, 32'hFFFF_FF1F);
        alu(2'b10, 6'b100100, 32'h0000_000F, 32'h0000_00F0);
        check("r_and_ctl", {28'h0, alu_control}, 32'h0);
        check("r_and", alu_result, 32'h0);
        check("r_and_zero", {31'h0, zero}, 32'h1);
        alu(2'b10, 6'b100101, 32'h0000_000F, 32'h0000_00F0);
        check("r_or_ctl", {28'h0, alu_control}, 32'h1);
        check("r_or", alu_result, 32'h0000_00FF);
        check("r_or_zero", {31'h0, zero}, 32'h0);
        alu(2'b10, 6'b100111, 32'h0000_000F, 32'h0000_00F0);
        check("r_nor_ctl", {28'h0, alu_control}, 32'hC);
        check("r_nor", alu_result, 32'hFFFF_FF00);
        alu(2'b10, 6'b101010, 32'h0000_000F, 32'h0000_00F0);
        check("r_slt_ctl", {28'h0, alu_control}, 32'h7);
        check("r_slt", alu_result, 32'h1);
        alu(2'b10, 6'b000000, 32'h0000_000F, 32'h0000_00F0);
        check("r_bad_ctl", {28'h0, alu_control}, 32'hF);
        check("r_bad", alu_result, 32'h0);
        check("r_bad_zero", {31'h0, zero}, 32'h1);

        alu(2'b01, 6'b100101, 32'h1234_5678, 32'h1234_5678);
        check("beq_ctl", {28'h0, alu_control}, 32'h6);
        check("beq_res", alu_result, 32'h0);
        check("beq_zero", {31'h0, zero}, 32'h1);
        alu(2'b01, 6'b100101, 32'h1234_5678, 32'h1234_5679);
        check("bne_res", alu_result, 32'hFFFF_FFFF);
        check("bne_zero", {31'h0, zero}, 32'h0);

        alu(2'b00, 6'b100010, 32'h0000_0010, 32'h0000_0004);
        check("lw_ctl", {28'h0, alu_control}, 32'h2);
        check("lw_res", alu_result, 32'h14);
        alu(2'b11, 6'b100000, 32'h0000_FF0F, 32'h0000_0FF0);
        check("andi_ctl", {28'h0, alu_control}, 32'h0);
        check("andi_res", alu_result, 32'h0000_0F00);

        alu(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_neg", alu_result, 32'h1);
        alu(2'b10, 6'b101010, 32'h0000_0001, 32'hFFFF_FFFF);
        check("slt_pos", alu_result, 32'h0);
        check("slt_pos_zero", {31'h0, zero}, 32'h1);

        // combinational outputs remain live while reset is held
        rst_n = 1'b0;
        alu(2'b00, 6'b0, 32'h0000_0003, 32'h0000_0005);
        check("alu_in_rst", alu_result, 32'h8);
        rst_n = 1'b1;

`ifdef ALU_OVERFLOW_EN
        alu(2'b00, 6'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        check("ovf_add_res", alu_result, 32'h8000_0000);
        check("ovf_add", {31'h0, overflow}, 32'h1);
        alu(2'b00, 6'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        check("novf_add_res", alu_result, 32'h0);
        check("novf_zero", {31'h0, zero}, 32'h1);
        check("novf_add", {31'h0, overflow}, 32'h0);
        alu(2'b01, 6'b0, 32'h8000_0000, 32'h0000_0001);
        check("ovf_sub_res", alu_result, 32'h7FFF_FFFF);
        check("ovf_sub", {31'h0, overflow}, 32'h1);
        alu(2'b11, 6'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("ovf_and", {31'h0, overflow}, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
